// File: rtl/sap_instr_reg_multibyte_pkg.sv
// Shared types and helpers for the multibyte SAP instruction register.
// Holds the sequencer state encoding, a clog2 helper and the long-opcode predicate.
package sap_ir_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_EXT   = 2'd1,
        ST_FULL  = 2'd2
    } ir_state_t;

    // Never returns less than 1 so that selector ports always have at least one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic is_long_opc(input logic first_byte_msb);
        return first_byte_msb;
    endfunction

endpackage

// File: rtl/sap_instr_reg_multibyte_lane_reg.sv
// Generic W-bit holding register with async reset, sync clear and load enable.
// Latency: 1 cycle from enable to q. No backpressure; clear wins over load.
module ir_lane_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         n_clr,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sap_instr_reg_multibyte.sv
// Multibyte SAP instruction register: captures short or long instructions from the W bus.
// Latency: opcode/operand visible 1 cycle after the load edge; bus drive is combinational.
// Backpressure: none; need_byte requests extension bytes, n_l1 gaps simply hold state.
module sap_instr_reg_multibyte
    import sap_ir_pkg::*;
#(
    parameter  int BUS_W     = 8,
    parameter  int OPC_W     = 4,
    parameter  int EXT_BYTES = 2,
    localparam int SEL_W     = clog2(EXT_BYTES),
    localparam int OPR_W     = EXT_BYTES * BUS_W
) (
    input  logic             clk,
    input  logic             n_clr,
    input  logic [BUS_W-1:0] d,
    input  logic             n_l1,
    input  logic             flush,
    input  logic             n_e1,
    input  logic [SEL_W-1:0] e_sel,
    output logic [OPC_W-1:0] opcode,
    output logic [OPR_W-1:0] operand,
    output logic [BUS_W-1:0] s_bus,
    output logic             s_bus_en,
    output logic             need_byte,
    output logic             ir_ready
);

    if (OPC_W >= BUS_W || EXT_BYTES < 1) begin : g_bad_params
        $error("sap_instr_reg_multibyte: need OPC_W < BUS_W and EXT_BYTES >= 1");
    end

    ir_state_t          state;
    logic [SEL_W-1:0]   cnt;

    logic               load;
    logic               new_ld;
    logic               ext_ld;
    logic               long_in;
    logic [BUS_W-1:0]   zext_d;
    logic [BUS_W-1:0]   lane_q [EXT_BYTES];

    assign load    = ~n_l1 & ~flush;
    assign new_ld  = load & (state != ST_EXT);
    assign ext_ld  = load & (state == ST_EXT);
    assign long_in = is_long_opc(d[BUS_W-1]);
    assign zext_d  = {{OPC_W{1'b0}}, d[BUS_W-OPC_W-1:0]};

    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            state     <= ST_EMPTY;
            cnt       <= '0;
            need_byte <= 1'b0;
            ir_ready  <= 1'b0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            cnt       <= '0;
            need_byte <= 1'b0;
            ir_ready  <= 1'b0;
        end else if (!n_l1) begin
            case (state)
                ST_EMPTY, ST_FULL: begin
                    cnt <= '0;
                    if (long_in) begin
                        state     <= ST_EXT;
                        need_byte <= 1'b1;
                        ir_ready  <= 1'b0;
                    end else begin
                        state     <= ST_FULL;
                        need_byte <= 1'b0;
                        ir_ready  <= 1'b1;
                    end
                end
                ST_EXT: begin
                    if (cnt == SEL_W'(EXT_BYTES - 1)) begin
                        state     <= ST_FULL;
                        cnt       <= '0;
                        need_byte <= 1'b0;
                        ir_ready  <= 1'b1;
                    end else begin
                        cnt <= cnt + SEL_W'(1);
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    cnt       <= '0;
                    need_byte <= 1'b0;
                    ir_ready  <= 1'b0;
                end
            endcase
        end
    end

    ir_lane_reg #(.W(OPC_W)) u_opc (
        .clk   (clk),
        .n_clr (n_clr),
        .clr   (flush),
        .en    (new_ld),
        .d     (d[BUS_W-1 -: OPC_W]),
        .q     (opcode)
    );

    // A new instruction clears every lane except lane 0 of a short one, which takes the low field.
    for (genvar i = 0; i < EXT_BYTES; i++) begin : g_lane
        logic             lane_clr;
        logic             lane_en;
        logic [BUS_W-1:0] lane_d;

        assign lane_clr = flush | (new_ld & (long_in | (i != 0)));
        assign lane_en  = (ext_ld & (cnt == SEL_W'(i))) | (new_ld & ~long_in & (i == 0));
        assign lane_d   = (state == ST_EXT) ? d : zext_d;

        ir_lane_reg #(.W(BUS_W)) u_lane (
            .clk   (clk),
            .n_clr (n_clr),
            .clr   (lane_clr),
            .en    (lane_en),
            .d     (lane_d),
            .q     (lane_q[i])
        );

        assign operand[i*BUS_W +: BUS_W] = lane_q[i];
    end

    logic             sel_hit;
    logic [BUS_W-1:0] sel_dat;

    always_comb begin
        sel_hit = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < EXT_BYTES; i++) begin
            if (e_sel == SEL_W'(i)) begin
                sel_hit = 1'b1;
                sel_dat = lane_q[i];
            end
        end
        s_bus_en = ~n_e1 & ir_ready & sel_hit;
        s_bus    = s_bus_en ? sel_dat : '0;
    end

endmodule

// File: tb/tb_sap_instr_reg_multibyte.sv
// Directed table-driven bench for the multibyte instruction register, plus hand sequences
// for async reset mid-fetch and an out-of-range lane select on a 3-byte-operand instance.
module tb_sap_instr_reg_multibyte;

    logic        clk;
    logic        n_clr;
    logic [7:0]  d;
    logic        n_l1;
    logic        flush;
    logic        n_e1;
    logic [0:0]  e_sel;
    logic [3:0]  opcode;
    logic [15:0] operand;
    logic [7:0]  s_bus;
    logic        s_bus_en;
    logic        need_byte;
    logic        ir_ready;

    logic [7:0]  d3;
    logic        n_l13;
    logic        flush3;
    logic        n_e13;
    logic [1:0]  e_sel3;
    logic [3:0]  opcode3;
    logic [23:0] operand3;
    logic [7:0]  s_bus3;
    logic        s_bus_en3;
    logic        need_byte3;
    logic        ir_ready3;

    int pass_cnt;
    int total_cnt;

    sap_instr_reg_multibyte #(.BUS_W(8), .OPC_W(4), .EXT_BYTES(2)) u_dut (
        .clk       (clk),
        .n_clr     (n_clr),
        .d         (d),
        .n_l1      (n_l1),
        .flush     (flush),
        .n_e1      (n_e1),
        .e_sel     (e_sel),
        .opcode    (opcode),
        .operand   (operand),
        .s_bus     (s_bus),
        .s_bus_en  (s_bus_en),
        .need_byte (need_byte),
        .ir_ready  (ir_ready)
    );

    sap_instr_reg_multibyte #(.BUS_W(8), .OPC_W(4), .EXT_BYTES(3)) u_dut3 (
        .clk       (clk),
        .n_clr     (n_clr),
        .d         (d3),
        .n_l1      (n_l13),
        .flush     (flush3),
        .n_e1      (n_e13),
        .e_sel     (e_sel3),
        .opcode    (opcode3),
        .operand   (operand3),
        .s_bus     (s_bus3),
        .s_bus_en  (s_bus_en3),
        .need_byte (need_byte3),
        .ir_ready  (ir_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        n_l1;
        logic        flush;
        logic        n_e1;
        logic [0:0]  e_sel;
        logic [7:0]  d;
        logic [3:0]  opcode;
        logic [15:0] operand;
        logic [7:0]  s_bus;
        logic        s_bus_en;
        logic        need_byte;
        logic        ir_ready;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(string nm, logic l, logic f, logic e, logic [0:0] es,
                                logic [7:0] dd, logic [3:0] opc, logic [15:0] opr,
                                logic [7:0] sb, logic sen, logic nb, logic rdy);
        vec_t v;
        v.name = nm; v.n_l1 = l; v.flush = f; v.n_e1 = e; v.e_sel = es; v.d = dd;
        v.opcode = opc; v.operand = opr; v.s_bus = sb; v.s_bus_en = sen;
        v.need_byte = nb; v.ir_ready = rdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] opc, input logic [15:0] opr,
                           input logic [7:0] sb, input logic sen, input logic nb,
                           input logic rdy);
        chk({tag, ".opcode"},    32'(opcode),    32'(opc));
        chk({tag, ".operand"},   32'(operand),   32'(opr));
        chk({tag, ".s_bus"},     32'(s_bus),     32'(sb));
        chk({tag, ".s_bus_en"},  32'(s_bus_en),  32'(sen));
        chk({tag, ".need_byte"}, 32'(need_byte), 32'(nb));
        chk({tag, ".ir_ready"},  32'(ir_ready),  32'(rdy));
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;

        //                 name        n_l1 fl  n_e1 sel d      opc   operand  s_bus en nb rdy
        vecs[0]  = mk("short_2A",  0, 0, 0, 0, 8'h2A, 4'h2, 16'h000A, 8'h0A, 1, 0, 1);
        vecs[1]  = mk("hold",      1, 0, 1, 0, 8'hFF, 4'h2, 16'h000A, 8'h00, 0, 0, 1);
        vecs[2]  = mk("b2b_35",    0, 0, 0, 0, 8'h35, 4'h3, 16'h0005, 8'h05, 1, 0, 1);
        vecs[3]  = mk("long_9F",   0, 0, 0, 0, 8'h9F, 4'h9, 16'h0000, 8'h00, 0, 1, 0);
        vecs[4]  = mk("ext_34",    0, 0, 0, 0, 8'h34, 4'h9, 16'h0034, 8'h00, 0, 1, 0);
        vecs[5]  = mk("gap",       1, 0, 0, 1, 8'h00, 4'h9, 16'h0034, 8'h00, 0, 1, 0);
        vecs[6]  = mk("ext_12",    0, 0, 0, 1, 8'h12, 4'h9, 16'h1234, 8'h12, 1, 0, 1);
        vecs[7]  = mk("lane0",     1, 0, 0, 0, 8'h00, 4'h9, 16'h1234, 8'h34, 1, 0, 1);
        vecs[8]  = mk("long_C0",   0, 0, 0, 0, 8'hC0, 4'hC, 16'h0000, 8'h00, 0, 1, 0);
        vecs[9]  = mk("flush_ld",  0, 1, 0, 0, 8'h55, 4'h0, 16'h0000, 8'h00, 0, 0, 0);
        vecs[10] = mk("long_8F",   0, 0, 1, 0, 8'h8F, 4'h8, 16'h0000, 8'h00, 0, 1, 0);
        vecs[11] = mk("ext_AB",    0, 0, 0, 0, 8'hAB, 4'h8, 16'h00AB, 8'h00, 0, 1, 0);

        n_clr = 1'b0; d = 8'h00; n_l1 = 1'b1; flush = 1'b0; n_e1 = 1'b0; e_sel = 1'b0;
        d3 = 8'h00; n_l13 = 1'b1; flush3 = 1'b0; n_e13 = 1'b1; e_sel3 = 2'd0;

        #2;
        chk_all("reset", 4'h0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        n_clr = 1'b1;
        tick();

        foreach (vecs[i]) begin
            n_l1 = vecs[i].n_l1; flush = vecs[i].flush; n_e1 = vecs[i].n_e1;
            e_sel = vecs[i].e_sel; d = vecs[i].d;
            tick();
            chk_all(vecs[i].name, vecs[i].opcode, vecs[i].operand, vecs[i].s_bus,
                    vecs[i].s_bus_en, vecs[i].need_byte, vecs[i].ir_ready);
        end

        // Async reset between edges while mid-fetch: outputs clear before the next clock.
        n_l1 = 1'b0; d = 8'h2A; n_e1 = 1'b0; e_sel = 1'b0; flush = 1'b0;
        #3;
        n_clr = 1'b0;
        #1;
        chk_all("async_rst", 4'h0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("rst_held", 4'h0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        #3;
        n_clr = 1'b1;
        tick();
        chk_all("post_rst_2A", 4'h2, 16'h000A, 8'h0A, 1'b1, 1'b0, 1'b1);
        n_l1 = 1'b1;

        // 3-byte operand instance: full fetch, top lane drive, then an unreachable lane.
        n_l13 = 1'b0;
        d3 = 8'hA1; tick();
        chk("x3.need_byte", 32'(need_byte3), 32'd1);
        d3 = 8'h11; tick();
        d3 = 8'h22; tick();
        chk("x3.mid_ready", 32'(ir_ready3), 32'd0);
        d3 = 8'h33; tick();
        n_l13 = 1'b1;
        chk("x3.opcode",  32'(opcode3),  32'h0000000A);
        chk("x3.operand", 32'(operand3), 32'h00332211);
        chk("x3.ready",   32'(ir_ready3), 32'd1);
        n_e13 = 1'b0; e_sel3 = 2'd2;
        #1;
        chk("x3.sel2_bus", 32'(s_bus3),    32'h00000033);
        chk("x3.sel2_en",  32'(s_bus_en3), 32'd1);
        e_sel3 = 2'd3;
        #1;
        chk("x3.sel3_en",  32'(s_bus_en3), 32'd0);
        chk("x3.sel3_bus", 32'(s_bus3),    32'h00000000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
